fft_mag_stream: RTL and testbench
=================================

FFT_MAG_STREAM -- requirements
Module: fft_mag_stream

Interface
REQ-001 SHALL have parameter IN_W, 28, signed width of the real and imaginary FFT inputs.
REQ-002 SHALL have parameter OUT_W, 16, signed width of quantised components and of m_mag.
REQ-003 SHALL have parameter USER_W, 11, width of the bin-index sideband.
REQ-004 SHALL have parameter FRAC_SHIFT, 9, arithmetic right shift applied before quantisation.
REQ-005 SHALL have parameter ITER, 12, number of CORDIC vectoring iterations (range 8..OUT_W).
REQ-006 SHALL have parameter INT_BIT, 2, output right shift that reserves integer headroom.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have the input stream ports: s_valid (in, 1), s_ready (out, 1), s_last (in, 1, end of frame), s_user (in, USER_W, bin index), s_re (in, IN_W), s_im (in, IN_W).
REQ-010 SHALL have the output stream ports: m_valid (out, 1), m_ready (in, 1), m_last (out, 1), m_user (out, USER_W), m_mag (out, OUT_W, magnitude with MSB always 0).
REQ-011 SHALL have, when FFT_MAG_PEAK_EN is defined, peak_valid (out, 1), peak_mag (out, OUT_W) and peak_user (out, USER_W).

Function
REQ-012 SHALL quantise each component as q = sat_OUT_W(x >>> FRAC_SHIFT), rounding toward minus infinity and clamping to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-013 SHALL take |q| of both components, swap them so that x >= y, and then run ITER registered vectoring stages; stage i applies the shift i and uses the sign of y to choose the direction.
REQ-014 SHALL size the internal datapath at OUT_W+2 bits unsigned so that CORDIC growth (up to 1.647·√2·full scale) never wraps.
REQ-015 SHALL compensate the CORDIC gain by multiplying by K_INV = 39797 (0.60725 in Q0.16), rounding half-up and saturating to 2^(OUT_W-1)-1.
REQ-016 SHALL form m_mag as compensated magnitude >> INT_BIT, zero-filled from the MSB.
REQ-017 SHALL have a latency from input acceptance to m_valid of exactly ITER+3 cycles while m_ready stays high (input register, abs/swap, ITER stages, compensation).
REQ-018 SHALL accept one beat per cycle when unstalled.
REQ-019 SHALL use a global enable en = !m_valid || m_ready, drive s_ready = en, and advance every pipeline register only when en is high.
REQ-020 SHALL propagate s_last and s_user together with their own beat; bubbles carry valid=0.
REQ-021 SHALL hold m_valid/m_mag/m_last/m_user stable while m_valid && !m_ready.
REQ-022 SHALL produce m_mag = 0 for a zero input (q_re = q_im = 0).
REQ-023 SHALL produce a peak result, when FFT_MAG_PEAK_EN is set, as follows: track the maximum m_mag of each output frame and its m_user; ties keep the earliest bin; on the cycle the m_last beat is handshaken, peak_valid pulses for 1 cycle with that frame's result (a single-beat frame reports itself), and the tracker reloads for the next frame.

Reset
REQ-024 SHALL, on reset, clear all pipeline valids, m_valid, m_last, m_user, m_mag, peak_valid, peak_mag and peak_user to 0.
REQ-025 SHALL, on reset mid-frame, discard in-flight beats and the partial peak; s_ready is 1 on the first cycle after reset.

Configuration
REQ-026 SHALL, when FFT_MAG_PEAK_EN is defined, include the peak tracker and the peak ports.
REQ-027 SHALL, when FFT_MAG_PEAK_EN is undefined, omit the tracker logic and the peak ports; stream behaviour is identical in both builds.

Structure
REQ-028 SHALL place K_INV, its width (16) and the default-parameter constants in package fft_mag_pkg.
REQ-029 SHALL implement one vectoring iteration (shift-add plus register with enable) as sub-module cordic_vec_stage, instantiated ITER times by a generate loop.

Verification
REQ-030 SHALL verify the basic magnitude: s_re = 300<<9, s_im = 400<<9, m_ready = 1 -> m_mag = 125±1 exactly 15 cycles later.
REQ-031 SHALL verify saturation: s_re = 2^27-1, s_im = -2^27 -> q = (32767, -32768) -> m_mag = 8191 with no wrap.
REQ-032 SHALL verify backpressure: a 2048-beat frame with m_ready toggling pseudo-randomly -> the output sequence equals the unstalled reference and m_last lands on user = 2047.
REQ-033 SHALL verify the peak tracker (PEAK_EN build): frame magnitudes {10, 50, 50, 7} at user 0..3 -> a single peak_valid pulse with peak_mag = 50 and peak_user = 1.
REQ-034 SHALL verify reset mid-frame: reset asserted while 5 beats are in flight -> no further m_valid, no peak_valid, and the next frame is processed correctly.

Source files
------------

// File: rtl/fft_mag_pkg.sv
// Shared constants for the FFT magnitude stream: CORDIC gain compensation and default parameters.
package fft_mag_pkg;

  localparam int unsigned K_INV_W = 16;
  localparam logic [K_INV_W-1:0] K_INV = 16'd39797;

  localparam int unsigned DEF_IN_W       = 28;
  localparam int unsigned DEF_OUT_W      = 16;
  localparam int unsigned DEF_USER_W     = 11;
  localparam int unsigned DEF_FRAC_SHIFT = 9;
  localparam int unsigned DEF_ITER       = 12;
  localparam int unsigned DEF_INT_BIT    = 2;

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered CORDIC vectoring iteration: rotate (x, y) toward y = 0 using shift SHIFT.
module cordic_vec_stage
  import fft_mag_pkg::*;
#(
  parameter int unsigned W      = DEF_OUT_W + 2,
  parameter int unsigned USER_W = DEF_USER_W,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [USER_W-1:0]   in_user,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_y,
  output logic                out_valid,
  output logic                out_last,
  output logic [USER_W-1:0]   out_user,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y
);

  logic signed [W-1:0] nx;
  logic signed [W-1:0] ny;

  always_comb begin
    nx = in_x;
    ny = in_y;
    if (in_y[W-1]) begin
      nx = in_x - (in_y >>> SHIFT);
      ny = in_y + (in_x >>> SHIFT);
    end else begin
      nx = in_x + (in_y >>> SHIFT);
      ny = in_y - (in_x >>> SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_user  <= in_user;
      out_x     <= nx;
      out_y     <= ny;
    end
  end

endmodule

// File: rtl/fft_mag_stream.sv
// Streaming |re + j*im| of FFT bins via quantise, abs/swap, CORDIC vectoring and gain compensation.
// Optional per-frame peak tracker and peak ports are built when FFT_MAG_PEAK_EN is defined.
module fft_mag_stream
  import fft_mag_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned USER_W     = DEF_USER_W,
  parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int unsigned ITER       = DEF_ITER,
  parameter int unsigned INT_BIT    = DEF_INT_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [USER_W-1:0]      s_user,
  input  logic signed [IN_W-1:0] s_re,
  input  logic signed [IN_W-1:0] s_im,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [USER_W-1:0]      m_user,
  output logic [OUT_W-1:0]       m_mag
`ifdef FFT_MAG_PEAK_EN
  ,
  output logic                   peak_valid,
  output logic [OUT_W-1:0]       peak_mag,
  output logic [USER_W-1:0]      peak_user
`endif
);

  localparam int unsigned W  = OUT_W + 2;
  localparam int unsigned PW = W + K_INV_W;
  localparam logic signed [IN_W-1:0] Q_MAX = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [IN_W-1:0] Q_MIN = ~Q_MAX;
  localparam logic [W-1:0]  MAG_MAX = W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [PW-1:0] HALF    = PW'(64'd1 << (K_INV_W - 1));

  logic en;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  function automatic logic signed [OUT_W-1:0] quant(input logic signed [IN_W-1:0] v);
    logic signed [IN_W-1:0] sh;
    sh = v >>> FRAC_SHIFT;
    if (sh > Q_MAX) sh = Q_MAX;
    else if (sh < Q_MIN) sh = Q_MIN;
    return OUT_W'(sh);
  endfunction

  // Input register holds the quantised components.
  logic                    v1, last1;
  logic [USER_W-1:0]       user1;
  logic signed [OUT_W-1:0] q_re1, q_im1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      user1 <= '0;
      q_re1 <= '0;
      q_im1 <= '0;
    end else if (en) begin
      v1    <= s_valid;
      last1 <= s_last;
      user1 <= s_user;
      q_re1 <= quant(s_re);
      q_im1 <= quant(s_im);
    end
  end

  // |q| is widened first so that |-2^(OUT_W-1)| does not overflow.
  logic signed [W-1:0] ext_re, ext_im, a_re, a_im;

  always_comb begin
    ext_re = W'(q_re1);
    ext_im = W'(q_im1);
    a_re   = q_re1[OUT_W-1] ? -ext_re : ext_re;
    a_im   = q_im1[OUT_W-1] ? -ext_im : ext_im;
  end

  logic                v2, last2;
  logic [USER_W-1:0]   user2;
  logic signed [W-1:0] x2, y2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      user2 <= '0;
      x2    <= '0;
      y2    <= '0;
    end else if (en) begin
      v2    <= v1;
      last2 <= last1;
      user2 <= user1;
      x2    <= (a_re >= a_im) ? a_re : a_im;
      y2    <= (a_re >= a_im) ? a_im : a_re;
    end
  end

  logic                cv [ITER];
  logic                cl [ITER];
  logic [USER_W-1:0]   cu [ITER];
  logic signed [W-1:0] cx [ITER];
  logic signed [W-1:0] cy [ITER];

  for (genvar k = 0; k < ITER; k++) begin : g_stage
    if (k == 0) begin : g_first
      cordic_vec_stage #(.W(W), .USER_W(USER_W), .SHIFT(k)) u_stage (
        .clk(clk), .reset(reset), .en(en),
        .in_valid(v2), .in_last(last2), .in_user(user2), .in_x(x2), .in_y(y2),
        .out_valid(cv[k]), .out_last(cl[k]), .out_user(cu[k]), .out_x(cx[k]), .out_y(cy[k])
      );
    end else begin : g_next
      cordic_vec_stage #(.W(W), .USER_W(USER_W), .SHIFT(k)) u_stage (
        .clk(clk), .reset(reset), .en(en),
        .in_valid(cv[k-1]), .in_last(cl[k-1]), .in_user(cu[k-1]),
        .in_x(cx[k-1]), .in_y(cy[k-1]),
        .out_valid(cv[k]), .out_last(cl[k]), .out_user(cu[k]), .out_x(cx[k]), .out_y(cy[k])
      );
    end
  end

  // Gain compensation, round half-up, saturate to the positive OUT_W range.
  logic [PW-1:0] prod, rnd;
  logic [W-1:0]  comp, comp_sat;

  always_comb begin
    prod     = PW'($unsigned(cx[ITER-1])) * PW'(K_INV);
    rnd      = prod + HALF;
    comp     = W'(rnd >> K_INV_W);
    comp_sat = (comp > MAG_MAX) ? MAG_MAX : comp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_user  <= '0;
      m_mag   <= '0;
    end else if (en) begin
      m_valid <= cv[ITER-1];
      m_last  <= cl[ITER-1];
      m_user  <= cu[ITER-1];
      m_mag   <= OUT_W'(comp_sat >> INT_BIT);
    end
  end

`ifdef FFT_MAG_PEAK_EN
  // Running maximum over the output frame; strict compare keeps the earliest bin on ties.
  logic              hs, have, take;
  logic [OUT_W-1:0]  best_mag, cand_mag;
  logic [USER_W-1:0] best_user, cand_user;

  always_comb begin
    hs        = m_valid && m_ready;
    take      = !have || (m_mag > best_mag);
    cand_mag  = take ? m_mag : best_mag;
    cand_user = take ? m_user : best_user;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      have       <= 1'b0;
      best_mag   <= '0;
      best_user  <= '0;
      peak_valid <= 1'b0;
      peak_mag   <= '0;
      peak_user  <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (hs) begin
        if (m_last) begin
          peak_valid <= 1'b1;
          peak_mag   <= cand_mag;
          peak_user  <= cand_user;
          have       <= 1'b0;
        end else begin
          best_mag  <= cand_mag;
          best_user <= cand_user;
          have      <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_mag_stream.sv
// Directed bench for fft_mag_stream; peak checks are compiled when FFT_MAG_PEAK_EN is defined.
module tb_fft_mag_stream;

  localparam int unsigned IN_W   = 28;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned USER_W = 11;
  localparam int unsigned ITER   = 12;
  localparam int          LAT    = ITER + 3;
  localparam int          FRAME  = 2048;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   s_valid, s_ready, s_last;
  logic [USER_W-1:0]      s_user;
  logic signed [IN_W-1:0] s_re, s_im;
  logic                   m_valid, m_ready, m_last;
  logic [USER_W-1:0]      m_user;
  logic [OUT_W-1:0]       m_mag;
`ifdef FFT_MAG_PEAK_EN
  logic                   peak_valid;
  logic [OUT_W-1:0]       peak_mag;
  logic [USER_W-1:0]      peak_user;
`endif

  always #5 clk = ~clk;

  fft_mag_stream dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_user(s_user),
    .s_re(s_re), .s_im(s_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_user(m_user), .m_mag(m_mag)
`ifdef FFT_MAG_PEAK_EN
    , .peak_valid(peak_valid), .peak_mag(peak_mag), .peak_user(peak_user)
`endif
  );

  typedef struct {
    logic signed [IN_W-1:0] re;
    logic signed [IN_W-1:0] im;
    logic [USER_W-1:0]      user;
    logic                   last;
    int                     mag;
    int                     tol;
  } vec_t;

  vec_t vecs [11];
  int   total = 0;
  int   bad   = 0;
  int   ref_mag [FRAME];
  int   got_n, err_mag, err_user, hold_err, last_user, last_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint want, input longint tol);
    total++;
    if (act < want - tol || act > want + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, want, tol);
    end
  endtask

  // One isolated beat with m_ready high: latency, magnitude and sideband.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    s_valid = 1'b1; s_re = v.re; s_im = v.im; s_user = v.user; s_last = v.last;
    check($sformatf("v%0d_s_ready", idx), s_ready, 1, 0);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      tick();
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, LAT, 0);
    check($sformatf("v%0d_mag", idx), m_mag, v.mag, v.tol);
    check($sformatf("v%0d_user", idx), m_user, v.user, 0);
    check($sformatf("v%0d_last", idx), m_last, v.last, 0);
    tick();
  endtask

  function automatic logic signed [IN_W-1:0] frame_re(input int i);
    if (i % 97 == 0) return 28'sh7FFFFFF;
    return IN_W'((((i * 37) % 4001) - 2000) * 512 + (i % 512));
  endfunction

  function automatic logic signed [IN_W-1:0] frame_im(input int i);
    if (i % 89 == 0) return 28'sh8000000;
    return IN_W'((((i * 53) % 6007) - 3000) * 512 + ((i * 7) % 512));
  endfunction

  // Streams one FRAME-beat frame; stalled runs compare against the unstalled reference.
  task automatic run_frame(input bit stall);
    int sent, cyc;
    bit prev_stall, in_hs;
    logic [OUT_W-1:0]  pm;
    logic [USER_W-1:0] pu;
    logic              pl;
    sent = 0; cyc = 0; prev_stall = 0; pm = '0; pu = '0; pl = 1'b0;
    got_n = 0; err_mag = 0; err_user = 0; hold_err = 0; last_user = -1; last_cnt = 0;
    while (got_n < FRAME && cyc < 20000) begin
      m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < FRAME && (!stall || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_re    = frame_re(sent);
        s_im    = frame_im(sent);
        s_user  = USER_W'(sent);
        s_last  = (sent == FRAME - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      #1;
      if (prev_stall && (!m_valid || m_mag != pm || m_user != pu || m_last != pl)) hold_err++;
      if (m_valid && m_ready) begin
        if (stall) begin
          if (int'(m_mag) != ref_mag[got_n]) err_mag++;
        end else begin
          ref_mag[got_n] = int'(m_mag);
        end
        if (m_user != USER_W'(got_n)) err_user++;
        if (m_last) begin
          last_user = int'(m_user);
          last_cnt++;
        end
        got_n++;
      end
      prev_stall = m_valid && !m_ready;
      pm = m_mag; pu = m_user; pl = m_last;
      in_hs = s_valid && s_ready;
      tick();
      if (in_hs) sent++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    int held_err, pulses, stray;
    logic [OUT_W-1:0] hm;
`ifdef FFT_MAG_PEAK_EN
    int pk_cnt, pk_mag, pk_user;
    int q_tab [4];
`endif

    vecs[0]  = '{28'sd0, 28'sd0, 11'd0, 1'b0, 0, 0};
    vecs[1]  = '{IN_W'(300 * 512), IN_W'(400 * 512), 11'd1, 1'b0, 125, 1};
    vecs[2]  = '{IN_W'(-300 * 512), IN_W'(400 * 512), 11'd2, 1'b1, 125, 1};
    vecs[3]  = '{IN_W'(400 * 512), IN_W'(-300 * 512), 11'd3, 1'b0, 125, 1};
    vecs[4]  = '{IN_W'(1000 * 512), 28'sd0, 11'd4, 1'b0, 250, 1};
    vecs[5]  = '{28'sd0, IN_W'(-2000 * 512), 11'd5, 1'b1, 500, 1};
    vecs[6]  = '{IN_W'(3000 * 512), IN_W'(4000 * 512), 11'd6, 1'b0, 1250, 1};
    vecs[7]  = '{28'sh7FFFFFF, 28'sh8000000, 11'd7, 1'b0, 8191, 0};
    vecs[8]  = '{IN_W'(-32768 * 512), IN_W'(-32768 * 512), 11'd8, 1'b0, 8191, 0};
    vecs[9]  = '{IN_W'(32767 * 512 + 511), 28'sd0, 11'd2047, 1'b1, 8191, 1};
    vecs[10] = '{28'sd511, 28'sd511, 11'd10, 1'b0, 0, 0};

    reset = 1'b1; m_ready = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    s_user = '0; s_re = '0; s_im = '0;
    tick(); tick();
    check("rst_m_valid", m_valid, 0, 0);
    check("rst_m_mag", m_mag, 0, 0);
    check("rst_m_last", m_last, 0, 0);
    check("rst_m_user", m_user, 0, 0);
    reset = 1'b0;
    tick();
    check("rst_s_ready", s_ready, 1, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Output stalled: result must hold and input must be refused.
    m_ready = 1'b0;
    s_valid = 1'b1; s_re = IN_W'(300 * 512); s_im = IN_W'(400 * 512);
    s_user = 11'd33; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 40 && !m_valid; i++) tick();
    check("hold_valid", m_valid, 1, 0);
    check("hold_mag", m_mag, 125, 1);
    hm = m_mag;
    held_err = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!m_valid || m_mag != hm || m_user != 11'd33 || s_ready) held_err++;
    end
    check("hold_stable", held_err, 0, 0);
    m_ready = 1'b1;
    tick();
    check("hold_release", m_valid, 0, 0);

    run_frame(1'b0);
    check("ref_count", got_n, FRAME, 0);
    check("ref_user_seq", err_user, 0, 0);
    check("ref_last_user", last_user, FRAME - 1, 0);
    check("ref_last_cnt", last_cnt, 1, 0);
    check("ref_sat_bin0", ref_mag[0], 8191, 0);

    run_frame(1'b1);
    check("bp_count", got_n, FRAME, 0);
    check("bp_mag_seq", err_mag, 0, 0);
    check("bp_user_seq", err_user, 0, 0);
    check("bp_hold", hold_err, 0, 0);
    check("bp_last_user", last_user, FRAME - 1, 0);
    check("bp_last_cnt", last_cnt, 1, 0);
    for (int i = 0; i < 20; i++) tick();

`ifdef FFT_MAG_PEAK_EN
    q_tab[0] = 40; q_tab[1] = 200; q_tab[2] = 200; q_tab[3] = 28;
    for (int b = 0; b < 4; b++) begin
      s_valid = 1'b1; s_re = IN_W'(q_tab[b] * 512); s_im = '0;
      s_user = USER_W'(b); s_last = (b == 3);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    pk_cnt = 0; pk_mag = -1; pk_user = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (peak_valid) begin
        pk_cnt++;
        pk_mag  = int'(peak_mag);
        pk_user = int'(peak_user);
      end
    end
    check("peak_pulses", pk_cnt, 1, 0);
    check("peak_mag", pk_mag, 50, 1);
    check("peak_user", pk_user, 1, 0);
`endif

    // Reset while five beats (ending in s_last) are still in the pipeline.
    m_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      s_valid = 1'b1; s_re = IN_W'(1000 * 512); s_im = IN_W'(1000 * 512);
      s_user = USER_W'(b); s_last = (b == 4);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    reset = 1'b1; m_ready = 1'b0;
    tick(); tick();
    check("mid_rst_valid", m_valid, 0, 0);
    reset = 1'b0;
    tick();
    check("mid_rst_s_ready", s_ready, 1, 0);
    m_ready = 1'b1;
    pulses = 0; stray = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      if (m_valid) stray++;
`ifdef FFT_MAG_PEAK_EN
      if (peak_valid) pulses++;
`endif
    end
    check("mid_rst_no_out", stray, 0, 0);
    check("mid_rst_no_peak", pulses, 0, 0);
    run_vec(vecs[1], 100);
    run_vec(vecs[7], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
